// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the slave/master FSM state encodings.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic logic [1:0] resp_for(input logic ok);
    return ok ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axilite_regfile.sv
// NUM_REGS x 32 register array: one byte-enable write port and one combinational read port.
module axilite_regfile #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axilite_s.sv
// AXI4-Lite slave front end: independent write and read FSMs, address decode, registered outputs.
//
// state    | meaning
// W_IDLE   | waiting for AW and/or W
// W_HAVE_A | address latched, waiting for W
// W_HAVE_D | data/strobes latched, waiting for AW
// W_RESP   | write committed, holding B until bready
// R_IDLE   | waiting for AR
// R_DATA   | holding R until rready
module axilite_s
  import axilite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Any address bit above the word index makes the access out of range.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs, w_hs, ar_hs;
  logic              commit, latch_a, latch_d;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_data;
  logic [3:0]        c_strb;
  logic              c_ok, ar_ok;
  logic [31:0]       rf_rdata;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Whichever half arrived first comes from its holding register.
  assign c_addr = (w_state == W_HAVE_A) ? aw_addr_q : s_axi_awaddr;
  assign c_data = (w_state == W_HAVE_D) ? wdata_q : s_axi_wdata;
  assign c_strb = (w_state == W_HAVE_D) ? wstrb_q : s_axi_wstrb;
  assign c_ok   = in_range(c_addr);
  assign ar_ok  = in_range(s_axi_araddr);

  axilite_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .we    (commit && c_ok),
    .waddr (c_addr[IDX_W+1:2]),
    .wdata (c_data),
    .wstrb (c_strb),
    .raddr (s_axi_araddr[IDX_W+1:2]),
    .rdata (rf_rdata)
  );

  always_comb begin
    w_next  = w_state;
    commit  = 1'b0;
    latch_a = 1'b0;
    latch_d = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          latch_a = 1'b1;
          w_next  = W_HAVE_A;
        end else if (w_hs) begin
          latch_d = 1'b1;
          w_next  = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_rvalid && s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free flops.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      w_state       <= w_next;
      s_axi_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
      s_axi_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
      s_axi_bvalid  <= (w_next == W_RESP);
      if (commit) s_axi_bresp <= resp_for(c_ok);
      if (latch_a) aw_addr_q <= s_axi_awaddr;
      if (latch_d) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= (r_next == R_IDLE);
      s_axi_rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        s_axi_rdata <= ar_ok ? rf_rdata : 32'h0;
        s_axi_rresp <= resp_for(ar_ok);
      end
    end
  end

endmodule

// File: tb/tb_axilite_s.sv
// Directed self-checking bench for axilite_s (16 registers, 32-bit addresses).
module tb_axilite_s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  axilite_s #(.NUM_REGS(16), .ADDR_W(32)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp)
  );

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, ok, ha, hw;
    resp = 2'bxx;
    aw_done = 0; w_done = 0; ok = 0;
    @(negedge clk);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(negedge clk);
      if (ha) begin awvalid = 0; aw_done = 1; end
      if (hw) begin wvalid = 0; w_done = 1; end
    end
    awvalid = 0; wvalid = 0;
    for (int n = 0; n < 20 && aw_done && w_done && !ok; n++) begin
      if (bvalid) begin resp = bresp; ok = 1; end
      @(negedge clk);
    end
    bready = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL write_timeout addr=%h: no B response, required one within 20 cycles", a);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ar_done, ok;
    d = 'x; r = 'x; ar_done = 0; ok = 0;
    @(negedge clk);
    arvalid = 1; araddr = a; rready = 1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      if (arready) ar_done = 1;
      @(negedge clk);
    end
    arvalid = 0;
    for (int n = 0; n < 20 && ar_done && !ok; n++) begin
      if (rvalid) begin d = rdata; r = rresp; ok = 1; end
      @(negedge clk);
    end
    rready = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL read_timeout addr=%h: no R response, required one within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
      bad++;
      $display("FAIL reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_release_ready: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 0;
    total++;
    if ({awready, wready} !== 2'b11) begin
      bad++; $display("FAIL same_cycle_ready: got %b, required 11", {awready, wready});
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    total++;
    if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
      bad++; $display("FAIL same_cycle_b: got bvalid=%b bresp=%b aw=%b w=%b, required 1 00 0 0",
                      bvalid, bresp, awready, wready);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    total++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      bad++; $display("FAIL same_cycle_idle: got b=%b aw=%b w=%b, required 0 1 1", bvalid, awready, wready);
    end
    axi_read(32'h08, d, r);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      bad++; $display("FAIL same_cycle_read: got %h/%b, required deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        bad++; $display("FAIL w_first_wait%0d: got w=%b aw=%b b=%b, required 0 1 0", i, wready, awready, bvalid);
      end
      if (i < 2) @(negedge clk);
    end
    awvalid = 1; awaddr = 32'h10;
    @(negedge clk);
    awvalid = 0;
    total++;
    if ({bvalid, bresp} !== 3'b1_00) begin
      bad++; $display("FAIL w_first_b: got bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    axi_read(32'h10, d, r);
    total++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      bad++; $display("FAIL w_first_read: got %h/%b, required 12345678/00", d, r);
    end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awvalid = 1; awaddr = 32'h18;
    @(negedge clk);
    awvalid = 0;
    total++;
    if ({awready, wready} !== 2'b01) begin
      bad++; $display("FAIL aw_first_wait: got aw=%b w=%b, required 0 1", awready, wready);
    end
    wvalid = 1; wdata = 32'hA5A55A5A; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 0;
    total++;
    if ({bvalid, bresp} !== 3'b1_00) begin
      bad++; $display("FAIL aw_first_b: got bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    axi_read(32'h18, d, r);
    total++;
    if (d !== 32'hA5A55A5A || r !== 2'b00) begin
      bad++; $display("FAIL aw_first_read: got %h/%b, required a5a55a5a/00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h08, 32'h0000AAAA, 4'b0011, r);
    axi_read(32'h08, d, r);
    total++;
    if (d !== 32'hDEADAAAA || r !== 2'b00) begin
      bad++; $display("FAIL strobe_low: got %h/%b, required deadaaaa/00", d, r);
    end
    axi_write(32'h08, 32'h11223344, 4'b0100, r);
    axi_read(32'h08, d, r);
    total++;
    if (d !== 32'hDE22AAAA) begin
      bad++; $display("FAIL strobe_lane2: got %h, required de22aaaa", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h100, 32'hFFFFFFFF, 4'hF, r);
    total++;
    if (r !== 2'b11) begin
      bad++; $display("FAIL oor_bresp_100: got %b, required 11", r);
    end
    axi_read(32'h100, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b11) begin
      bad++; $display("FAIL oor_read_100: got %h/%b, required 00000000/11", d, r);
    end
    axi_read(32'h00, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b00) begin
      bad++; $display("FAIL oor_alias_reg0: got %h/%b, required 00000000/00", d, r);
    end
    axi_write(32'h40, 32'h99999999, 4'hF, r);
    total++;
    if (r !== 2'b11) begin
      bad++; $display("FAIL oor_bresp_40: got %b, required 11", r);
    end
    axi_write(32'h3C, 32'h76543210, 4'hF, r);
    total++;
    if (r !== 2'b00) begin
      bad++; $display("FAIL last_reg_bresp: got %b, required 00", r);
    end
    axi_read(32'h3F, d, r);
    total++;
    if (d !== 32'h76543210 || r !== 2'b00) begin
      bad++; $display("FAIL last_reg_read: got %h/%b, required 76543210/00", d, r);
    end
    axi_read(32'h08, d, r);
    total++;
    if (d !== 32'hDE22AAAA) begin
      bad++; $display("FAIL oor_no_side_effect: got %h, required de22aaaa", d);
    end
  endtask

  task automatic test_bready_stall();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; bready = 0;
    @(negedge clk);
    awaddr = 32'h0C; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bvalid, bresp, awready} !== 4'b1_00_0) begin
        bad++; $display("FAIL stall_hold%0d: got b=%b bresp=%b aw=%b, required 1 00 0", i, bvalid, bresp, awready);
      end
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    total++;
    if ({bvalid, awready} !== 2'b01) begin
      bad++; $display("FAIL stall_release: got b=%b aw=%b, required 0 1", bvalid, awready);
    end
    @(negedge clk);
    awvalid = 0;
    total++;
    if ({awready, wready} !== 2'b01) begin
      bad++; $display("FAIL stall_new_aw: got aw=%b w=%b, required 0 1", awready, wready);
    end
    wvalid = 1; wdata = 32'h0BADBEEF;
    @(negedge clk);
    wvalid = 0;
    bready = 1;
    @(negedge clk);
    bready = 0;
    axi_read(32'h0C, d, r);
    total++;
    if (d !== 32'h0BADBEEF) begin
      bad++; $display("FAIL stall_second_write: got %h, required 0badbeef", d);
    end
    axi_read(32'h04, d, r);
    total++;
    if (d !== 32'hCAFEF00D) begin
      bad++; $display("FAIL stall_first_write: got %h, required cafef00d", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h14, 32'h11111111, 4'hF, r);
    @(negedge clk);
    arvalid = 1; araddr = 32'h14; rready = 0;
    awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h22222222; wstrb = 4'hF; bready = 0;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    total++;
    if ({rvalid, rresp, bvalid} !== 4'b1_00_1 || rdata !== 32'h11111111) begin
      bad++; $display("FAIL collision_pre_write: got rvalid=%b rresp=%b bvalid=%b rdata=%h, required 1 00 1 11111111",
                      rvalid, rresp, bvalid, rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({rvalid, arready} !== 2'b10 || rdata !== 32'h11111111) begin
        bad++; $display("FAIL r_hold%0d: got rvalid=%b ar=%b rdata=%h, required 1 0 11111111", i, rvalid, arready, rdata);
      end
    end
    rready = 1; bready = 1;
    @(negedge clk);
    rready = 0; bready = 0;
    total++;
    if ({rvalid, arready} !== 2'b01) begin
      bad++; $display("FAIL r_release: got rvalid=%b ar=%b, required 0 1", rvalid, arready);
    end
    axi_read(32'h14, d, r);
    total++;
    if (d !== 32'h22222222) begin
      bad++; $display("FAIL collision_post_write: got %h, required 22222222", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF; bready = 0;
    arvalid = 1; araddr = 32'h3C; rready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    total++;
    if ({bvalid, rvalid} !== 2'b11) begin
      bad++; $display("FAIL mid_reset_setup: got b=%b r=%b, required 1 1", bvalid, rvalid);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
      bad++; $display("FAIL mid_reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h, required all 0",
                      awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL mid_reset_release: got %b, required 111", {awready, wready, arready});
    end
    axi_read(32'h08, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b00) begin
      bad++; $display("FAIL mid_reset_cleared: got %h/%b, required 00000000/00", d, r);
    end
  endtask

  initial begin
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; rready = 0; rst_n = 0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_aw_before_w();
    test_strobe();
    test_out_of_range();
    test_bready_stall();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axilite_s.md
AXILITE_S -- requirements
Module: axilite_s

Interface
REQ-001 Parameter NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
REQ-002 Parameter ADDR_W, 32, width of the awaddr and araddr ports.
REQ-003 s_axi_aclk  in  1  sole clock; all state updates on the rising edge.
REQ-004 s_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axi_awvalid  in  1  write address valid.
REQ-006 s_axi_awready  out  1  write address ready.
REQ-007 s_axi_awaddr  in  ADDR_W  write byte address.
REQ-008 s_axi_wvalid  in  1  write data valid.
REQ-009 s_axi_wready  out  1  write data ready.
REQ-010 s_axi_wdata  in  32  write data.
REQ-011 s_axi_wstrb  in  4  byte-lane enables; bit n enables wdata[8n+7:8n].
REQ-012 s_axi_bvalid  out  1  write response valid.
REQ-013 s_axi_bready  in  1  write response ready.
REQ-014 s_axi_bresp  out  2  write response code.
REQ-015 s_axi_arvalid  in  1  read address valid.
REQ-016 s_axi_arready  out  1  read address ready.
REQ-017 s_axi_araddr  in  ADDR_W  read byte address.
REQ-018 s_axi_rvalid  out  1  read data valid.
REQ-019 s_axi_rready  in  1  read data ready.
REQ-020 s_axi_rdata  out  32  read data.
REQ-021 s_axi_rresp  out  2  read response code.

Function
REQ-022 All outputs SHALL be registered; no combinational input-to-output paths.
REQ-023 Decode: word index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; any set bit above the index SHALL be out of range.
REQ-024 Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
REQ-025 W_IDLE: awready=1 and wready=1. AW and W both handshake in the same cycle -> commit, go to W_RESP. AW only -> latch address, go to W_HAVE_A. W only -> latch data and strobes, go to W_HAVE_D.
REQ-026 W_HAVE_A: awready=0, wready=1; on the W handshake -> commit, go to W_RESP.
REQ-026a W_HAVE_D: wready=0, awready=1; on the AW handshake -> commit, go to W_RESP.
REQ-027 Commit, in range: update only the strobed byte lanes at that edge, bresp=2'b00. Out of range: no register changes, bresp=2'b11 (DECERR).
REQ-028 bvalid SHALL rise the cycle after commit; bvalid and bresp SHALL hold until bvalid&&bready; then go to W_IDLE with awready=wready=1 the next cycle.
REQ-029 Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
REQ-030 AR handshake: capture rdata from the array (in range, rresp=2'b00) or 0 with rresp=2'b11 (out of range); rvalid rises the next cycle.
REQ-031 rvalid, rdata and rresp SHALL hold until rvalid&&rready; then R_IDLE, arready=1 the next cycle.
REQ-032 Read and write FSMs SHALL be independent. An AR handshake on the same edge as a commit to the same register SHALL return the pre-write value.
REQ-033 Worst-case handshake-to-response latency is 1 cycle, well inside the master's 15-cycle timeout.

Reset
REQ-034 Asserting s_axi_aresetn low SHALL immediately force both FSMs to idle and all registers to 0. While reset is asserted, every ready and valid output SHALL be 0 and bresp, rresp and rdata SHALL be 0. This holds even mid-transaction; partial writes SHALL be discarded.
REQ-035 The first cycle after reset release SHALL present awready=wready=arready=1.

Structure
REQ-036 Package axilite_pkg SHALL hold the response codes (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11) and the write and read state enums, so they are shared with axilite_m.
REQ-037 Sub-module axilite_regfile SHALL hold the NUM_REGS x 32 array, one byte-enable write port and one combinational read port; axilite_s holds both FSMs and the decode.

Verification
REQ-038 AW and W in the same cycle, addr 0x08, data 0xDEADBEEF, strb 4'hF -> bvalid the next cycle, bresp 00; then read 0x08 -> rdata 0xDEADBEEF, rresp 00.
REQ-039 W (0x12345678) sent 3 cycles before AW (0x10) -> wready low while waiting; commit on the AW edge; bvalid the next cycle; read 0x10 -> 0x12345678.
REQ-040 Register holds 0xDEADBEEF; write data 0x0000AAAA with strb 4'b0011 -> read returns 0xDEADAAAA.
REQ-041 Write to 0x100 -> bresp 11 and no register changes; read 0x100 -> rdata 0, rresp 11.
REQ-042 bready held low 5 cycles -> bvalid and bresp stable and awready=0 throughout; a new AW is accepted the cycle after the B handshake.
REQ-043 Reset asserted during W_RESP and R_DATA -> bvalid=rvalid=0 immediately; after release, reading 0x08 returns 0.
